avmm_cmd_master: RTL and testbench
==================================

# avmm_cmd_master

Avalon-MM master that turns a valid/ready command stream into single-beat reads and writes on the transceiver test system's memory-mapped bridge slave port. It is the initiator end of that bridge. Read data returns in order on a valid/ready response stream, buffered so the bus side never sees backpressure. The block sits between a host-side command source (UART/JTAG decoder or test sequencer) and the bridge.

## Interface
- ADDR_W, 13, Avalon address width (byte address, passed through unchanged)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- MAX_OUTSTANDING, 4, maximum reads in flight plus buffered responses; power of two, 2..16
- TIMEOUT_CYCLES, 1024, read watchdog limit; used only with the timeout feature
- clk_50_clk  in  1  single clock for all logic
- reset_50_reset  in  1  asynchronous, active-high reset
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_be  in  DATA_W/8  byte enables
- rsp_valid / rsp_ready  out/in  1  read-response handshake
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  response produced by timeout; data is 0xDEADBEEF
- avm_address  out  ADDR_W  bus address
- avm_read, avm_write  out  1  bus strobes
- avm_writedata  out  DATA_W  bus write data
- avm_byteenable  out  DATA_W/8  bus byte enables
- avm_burstcount  out  1  constant 1
- avm_debugaccess  out  1  constant 0
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  slave read data
- avm_readdatavalid  in  1  slave read-data strobe
- stray_count  out  8  count of readdatavalid pulses received with no read outstanding; saturates at 255

## Operation
- Reset values:
  - avm_read, avm_write, rsp_valid, rsp_err, stray_count, outstanding count, FIFO pointers: all 0.
  - avm_address, avm_writedata, avm_byteenable, rsp_rdata: 0.
  - cmd_ready: 0 while reset is asserted.
- Credit rule:
  - credits = MAX_OUTSTANDING − outstanding − fifo_count.
  - cmd_ready = !busy && credits > 0, regardless of the operation type.
- Two-state issue FSM, IDLE → BUSY:
  - On cmd_valid && cmd_ready, register the address, data and byte enables, assert avm_read or avm_write, and enter BUSY.
  - In BUSY, all avm_* outputs are held stable while avm_waitrequest = 1.
  - On the first cycle with avm_waitrequest = 0, the transfer completes; the strobe drops next cycle and the FSM returns to IDLE.
- Outstanding counter:
  - Increments when a read completes on the bus.
  - Decrements on avm_readdatavalid.
  - Both in the same cycle leave it unchanged.
- Response FIFO:
  - Depth MAX_OUTSTANDING, show-ahead.
  - Pushed on avm_readdatavalid when outstanding > 0.
  - Popped on rsp_valid && rsp_ready.
  - Simultaneous push and pop is allowed, including at full and at empty.
  - The credit rule guarantees the FIFO never overflows.
- Stray data: avm_readdatavalid with outstanding = 0 is dropped and increments stray_count.
- Writes produce no response.
- Reset asserted mid-transfer:
  - Strobes drop immediately.
  - In-flight reads are forgotten; their late data counts as stray.

## Timing
- Command accepted in cycle N → avm_read/avm_write high from N+1.
- Zero-wait slave: strobe high for exactly one cycle (N+1); cmd_ready high again at N+2. Peak rate is one command per 2 cycles.
- avm_readdatavalid in cycle M → rsp_valid and rsp_rdata valid at M+1.
- rsp_valid stays high, and rsp_rdata stays stable, until accepted.
- With credits exhausted, cmd_ready stays low until the cycle after a response pop.

## Configuration
- AVMM_CMD_MASTER_TIMEOUT_EN defined:
  - A watchdog counts cycles while outstanding > 0 and no avm_readdatavalid arrives; the count resets on every readdatavalid.
  - When the count reaches TIMEOUT_CYCLES, push one response per outstanding read, each with rsp_err = 1 and rsp_rdata = 0xDEADBEEF, one per cycle; then clear outstanding.
  - cmd_ready stays low during the flush.
  - Data arriving after the flush is stray.
- Macro undefined: no watchdog; rsp_err is tied to 0; reads wait indefinitely.

## Test plan
- Write 0x0000_1234 to address 0x010, be = 0xF, waitrequest held 3 cycles → avm_write high for 4 cycles with stable fields; no response; cmd_ready returns 1 cycle after completion.
- Read address 0x020, slave returns 0xCAFEF00D 2 cycles after acceptance → rsp_rdata = 0xCAFEF00D with rsp_valid asserted the cycle after readdatavalid.
- Issue 4 reads with rsp_ready = 0 → the 5th command sees cmd_ready = 0. After one pop, cmd_ready = 1 the following cycle; responses are in order.
- Pulse readdatavalid with no read pending, 3 times → stray_count = 3, no response produced.
- Assert reset during BUSY with waitrequest = 1 → avm_read = 0 immediately, outstanding = 0, rsp_valid = 0.
- With AVMM_CMD_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16: two reads, slave silent → after 16 idle cycles, two responses with rsp_err = 1 and data 0xDEADBEEF.

Source files
------------

// File: rtl/avmm_cmd_master.sv
// avmm_cmd_master
//   Avalon-MM initiator for the transceiver test system bridge. Converts a
//   valid/ready command stream into single-beat reads and writes and returns
//   read data, in order, on a valid/ready response stream. Read data is
//   buffered in a response FIFO. Issue is credit-limited so that the FIFO
//   can always absorb every read in flight, and the bus never sees
//   backpressure.
//
//   Ports
//     clk_50_clk, reset_50_reset      clock, async active-high reset
//     cmd_*                           command stream (write/read, addr, data, be)
//     rsp_*                           read-response stream (data, timeout error)
//     avm_*                           Avalon-MM master port
//     stray_count                     saturating count of unexpected readdatavalid
//
//   Build option
//     AVMM_CMD_MASTER_TIMEOUT_EN      enables the read watchdog. When it expires,
//                                     every outstanding read is answered with
//                                     rsp_err = 1 and data 0xDEADBEEF. Without
//                                     it, rsp_err is tied low and reads wait
//                                     forever.
//
//   state | meaning
//   IDLE  | no bus transfer pending; may accept a command
//   BUSY  | avm_read/avm_write asserted, waiting for waitrequest low

module avmm_cmd_master #(
    parameter int ADDR_W          = 13,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                clk_50_clk,
    input  logic                reset_50_reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_burstcount,
    output logic                avm_debugaccess,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic [7:0]          stray_count
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W:0] MAX_L = (CNT_W + 1)'(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING < 2 || MAX_OUTSTANDING > 16 ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("avmm_cmd_master: MAX_OUTSTANDING must be a power of two in 2..16, TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               avm_read_q, avm_read_d;
    logic               avm_write_q, avm_write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]         stray_q, stray_d;
    logic [DATA_W-1:0]  mem_q [MAX_OUTSTANDING];

    logic               rd_done;
    logic               have_out;
    logic               push;
    logic               pop;
    logic               rd_dec;
    logic               stray_hit;
    logic [DATA_W-1:0]  push_data;
    logic [CNT_W:0]     used;
    logic               flush_active;

`ifdef AVMM_CMD_MASTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] TO_L = WD_W'(TIMEOUT_CYCLES);

    logic               flush_q, flush_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               push_err;
    logic               err_mem_q [MAX_OUTSTANDING];

    assign flush_active = flush_q;
    assign rsp_err      = err_mem_q[rd_ptr_q];
`else
    assign flush_active = 1'b0;
    assign rsp_err      = 1'b0;
`endif

    // Credits count both reads still on the bus and responses already
    // buffered, so a granted read always has a FIFO slot waiting for it.
    assign used      = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
    assign cmd_ready = !reset_50_reset && (state_q == ST_IDLE) && !flush_active && (used < MAX_L);

    assign rsp_valid       = (fifo_cnt_q != '0);
    assign rsp_rdata       = mem_q[rd_ptr_q];
    assign avm_address     = addr_q;
    assign avm_read        = avm_read_q;
    assign avm_write       = avm_write_q;
    assign avm_writedata   = wdata_q;
    assign avm_byteenable  = be_q;
    assign avm_burstcount  = 1'b1;
    assign avm_debugaccess = 1'b0;
    assign stray_count     = stray_q;

    // Issue FSM: next state and registered bus outputs
    always_comb begin
        state_d     = state_q;
        avm_read_d  = avm_read_q;
        avm_write_d = avm_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    be_d        = cmd_be;
                    avm_read_d  = !cmd_write;
                    avm_write_d = cmd_write;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!avm_waitrequest) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read tracking, response FIFO bookkeeping, stray counter, watchdog
    always_comb begin
        rd_done   = avm_read_q && !avm_waitrequest;
        have_out  = (outstanding_q != '0);
        pop       = rsp_valid && rsp_ready;
        push      = avm_readdatavalid && have_out;
        push_data = avm_readdata;
        rd_dec    = push;
        stray_hit = avm_readdatavalid && !have_out;
`ifdef AVMM_CMD_MASTER_TIMEOUT_EN
        push_err = 1'b0;
        flush_d  = flush_q;
        // While flushing, each cycle retires one outstanding read with an
        // error response; real data arriving meanwhile is treated as stray.
        if (flush_q) begin
            push      = have_out;
            push_data = DATA_W'(32'hDEADBEEF);
            push_err  = 1'b1;
            rd_dec    = have_out;
            stray_hit = avm_readdatavalid;
        end
        if (flush_q || !have_out || avm_readdatavalid) begin
            wdog_d = TO_L;
        end else if (wdog_q == WD_W'(1)) begin
            wdog_d  = TO_L;
            flush_d = 1'b1;
        end else begin
            wdog_d = wdog_q - WD_W'(1);
        end
`endif
        outstanding_d = outstanding_q + CNT_W'(rd_done) - CNT_W'(rd_dec);
        fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        stray_d       = (stray_hit && stray_q != 8'hFF) ? stray_q + 8'd1 : stray_q;
`ifdef AVMM_CMD_MASTER_TIMEOUT_EN
        if (flush_q) begin
            flush_d = (outstanding_d != '0);
        end
`endif
    end

    always_ff @(posedge clk_50_clk or posedge reset_50_reset) begin
        if (reset_50_reset) begin
            state_q       <= ST_IDLE;
            avm_read_q    <= 1'b0;
            avm_write_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            outstanding_q <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            stray_q       <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                mem_q[i] <= '0;
            end
`ifdef AVMM_CMD_MASTER_TIMEOUT_EN
            flush_q <= 1'b0;
            wdog_q  <= TO_L;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                err_mem_q[i] <= 1'b0;
            end
`endif
        end else begin
            state_q       <= state_d;
            avm_read_q    <= avm_read_d;
            avm_write_q   <= avm_write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            outstanding_q <= outstanding_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            stray_q       <= stray_d;
            // Write slot and pop slot can coincide only when full; the popped
            // entry is consumed at this same edge, so overwriting it is safe.
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
`ifdef AVMM_CMD_MASTER_TIMEOUT_EN
            flush_q <= flush_d;
            wdog_q  <= wdog_d;
            if (push) begin
                err_mem_q[wr_ptr_q] <= push_err;
            end
`endif
        end
    end

endmodule

// File: tb/tb_avmm_cmd_master.sv
module tb_avmm_cmd_master;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [BE_W-1:0]   cmd_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [BE_W-1:0]   avm_byteenable;
    logic              avm_burstcount;
    logic              avm_debugaccess;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic [7:0]        stray_count;

    int n_tests = 0;
    int n_fail  = 0;

    avmm_cmd_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_OUTSTANDING(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_50_clk(clk),
        .reset_50_reset(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_be(cmd_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable),
        .avm_burstcount(avm_burstcount),
        .avm_debugaccess(avm_debugaccess),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .stray_count(stray_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
        rsp_ready = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        tick; tick;
        n_tests++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready);
        end
        n_tests++;
        if ({avm_read, avm_write, rsp_valid, rsp_err} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_strobes: got rd%b wr%b rv%b err%b want all 0", avm_read, avm_write, rsp_valid, rsp_err);
        end
        n_tests++;
        if ({avm_address, avm_writedata, avm_byteenable, rsp_rdata, stray_count} !== '0) begin
            n_fail++; $display("FAIL rst_fields: addr %h wd %h be %h rd %h stray %0d want 0", avm_address, avm_writedata, avm_byteenable, rsp_rdata, stray_count);
        end
        n_tests++;
        if ({avm_burstcount, avm_debugaccess} !== 2'b10) begin
            n_fail++; $display("FAIL rst_consts: burst %b dbg %b want 1/0", avm_burstcount, avm_debugaccess);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_rst_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'h010; cmd_wdata = 32'h0000_1234; cmd_be = 4'hF;
        avm_waitrequest = 1'b1;
        tick;
        cmd_valid = 1'b0; cmd_wdata = 32'hFFFF_FFFF; cmd_addr = 13'h1FFF;
        for (int i = 0; i < 4; i++) begin
            avm_waitrequest = (i < 3);
            n_tests++;
            if ({avm_write, avm_read, avm_address, avm_writedata, avm_byteenable, cmd_ready}
                !== {1'b1, 1'b0, 13'h010, 32'h0000_1234, 4'hF, 1'b0}) begin
                n_fail++; $display("FAIL wr_hold cyc%0d: wr%b rd%b addr %h wd %h be %h rdy%b want 1 0 010 00001234 f 0",
                                   i, avm_write, avm_read, avm_address, avm_writedata, avm_byteenable, cmd_ready);
            end
            tick;
        end
        avm_waitrequest = 1'b0;
        n_tests++;
        if ({avm_write, cmd_ready, rsp_valid} !== 3'b010) begin
            n_fail++; $display("FAIL wr_done: wr%b rdy%b rv%b want 0 1 0", avm_write, cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_read;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h020;
        avm_waitrequest = 1'b0;
        tick;
        cmd_valid = 1'b0;
        n_tests++;
        if ({avm_read, avm_write, avm_address} !== {1'b1, 1'b0, 13'h020}) begin
            n_fail++; $display("FAIL rd_strobe: rd%b wr%b addr %h want 1 0 020", avm_read, avm_write, avm_address);
        end
        tick;
        avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFE_F00D;
        n_tests++;
        if ({avm_read, rsp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL rd_drop: rd%b rv%b want 0 0", avm_read, rsp_valid);
        end
        tick;
        avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
                n_fail++; $display("FAIL rd_rsp cyc%0d: rv%b err%b data %h want 1 0 cafef00d", i, rsp_valid, rsp_err, rsp_rdata);
            end
            if (i == 0) tick;
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_pop: rv %b want 0", rsp_valid);
        end
    endtask

    task automatic test_credits;
        logic [31:0] exp_q [4];
        exp_q[0] = 32'h1001; exp_q[1] = 32'h1002; exp_q[2] = 32'h1003; exp_q[3] = 32'h2000;
        rsp_ready = 1'b0; avm_waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h100 + 13'(4 * k);
            tick;
            cmd_valid = 1'b0;
            tick;
            avm_readdatavalid = 1'b1; avm_readdata = 32'h1000 + 32'(k);
            tick;
            avm_readdatavalid = 1'b0;
        end
        cmd_valid = 1'b1; cmd_addr = 13'h200;
        n_tests++;
        if ({cmd_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b1, 32'h1000}) begin
            n_fail++; $display("FAIL cr_full: rdy%b rv%b data %h want 0 1 00001000", cmd_ready, rsp_valid, rsp_rdata);
        end
        tick;
        n_tests++;
        if ({avm_read, cmd_ready} !== 2'b00) begin
            n_fail++; $display("FAIL cr_blocked: rd%b rdy%b want 0 0", avm_read, cmd_ready);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL cr_after_pop: rdy %b want 1", cmd_ready);
        end
        tick;
        cmd_valid = 1'b0;
        n_tests++;
        if ({avm_read, avm_address} !== {1'b1, 13'h200}) begin
            n_fail++; $display("FAIL cr_5th: rd%b addr %h want 1 200", avm_read, avm_address);
        end
        tick;
        avm_readdatavalid = 1'b1; avm_readdata = 32'h2000;
        tick;
        avm_readdatavalid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            n_tests++;
            if ({rsp_valid, rsp_rdata} !== {1'b1, exp_q[j]}) begin
                n_fail++; $display("FAIL cr_order%0d: rv%b data %h want 1 %h", j, rsp_valid, rsp_rdata, exp_q[j]);
            end
            rsp_ready = 1'b1;
            tick;
            rsp_ready = 1'b0;
        end
        n_tests++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_fail++; $display("FAIL cr_drained: rv%b rdy%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_stray;
        for (int k = 0; k < 3; k++) begin
            avm_readdatavalid = 1'b1; avm_readdata = 32'h5555_0000 + 32'(k);
            tick;
            avm_readdatavalid = 1'b0;
            tick;
        end
        n_tests++;
        if ({stray_count, rsp_valid} !== {8'd3, 1'b0}) begin
            n_fail++; $display("FAIL stray: count %0d rv%b want 3 0", stray_count, rsp_valid);
        end
    endtask

    task automatic test_reset_mid;
        avm_waitrequest = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h030;
        tick;
        cmd_valid = 1'b0;
        tick;
        cmd_valid = 1'b1; cmd_addr = 13'h034; avm_waitrequest = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        n_tests++;
        if ({avm_read, avm_address} !== {1'b1, 13'h034}) begin
            n_fail++; $display("FAIL rm_stall: rd%b addr %h want 1 034", avm_read, avm_address);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({avm_read, cmd_ready, rsp_valid, stray_count} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++; $display("FAIL rm_async: rd%b rdy%b rv%b stray %0d want 0 0 0 0", avm_read, cmd_ready, rsp_valid, stray_count);
        end
        @(posedge clk);
        #1 rst = 1'b0; avm_waitrequest = 1'b0;
        #1;
        avm_readdatavalid = 1'b1; avm_readdata = 32'h0BAD_0BAD;
        tick;
        avm_readdatavalid = 1'b0;
        tick;
        n_tests++;
        if ({stray_count, rsp_valid, cmd_ready} !== {8'd1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL rm_late: stray %0d rv%b rdy%b want 1 0 1", stray_count, rsp_valid, cmd_ready);
        end
    endtask

`ifdef AVMM_CMD_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        int first;
        first = -1;
        rsp_ready = 1'b0; avm_waitrequest = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h040;
        tick;
        cmd_addr = 13'h044;
        tick;
        tick;
        cmd_valid = 1'b0;
        for (int t = 1; t <= 25; t++) begin
            if (t == 16) begin
                n_tests++;
                if (cmd_ready !== 1'b0) begin
                    n_fail++; $display("FAIL to_flush_ready: rdy %b want 0", cmd_ready);
                end
            end
            if (rsp_valid && first < 0) first = t;
            tick;
        end
        n_tests++;
        if (first != 17) begin
            n_fail++; $display("FAIL to_latency: first rsp at t=%0d want 17", first);
        end
        for (int j = 0; j < 2; j++) begin
            n_tests++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
                n_fail++; $display("FAIL to_rsp%0d: rv%b err%b data %h want 1 1 deadbeef", j, rsp_valid, rsp_err, rsp_rdata);
            end
            rsp_ready = 1'b1;
            tick;
            rsp_ready = 1'b0;
        end
        avm_readdatavalid = 1'b1; avm_readdata = 32'h1234_5678;
        tick;
        avm_readdatavalid = 1'b0;
        tick;
        n_tests++;
        if ({rsp_valid, stray_count, cmd_ready} !== {1'b0, 8'd2, 1'b1}) begin
            n_fail++; $display("FAIL to_after: rv%b stray %0d rdy%b want 0 2 1", rsp_valid, stray_count, cmd_ready);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_write;
        test_read;
        test_credits;
        test_stray;
        test_reset_mid;
`ifdef AVMM_CMD_MASTER_TIMEOUT_EN
        test_timeout;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, want finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule
